// File: rtl/rob_pkg.sv
// Shared widths and the entry record for the reorder buffer.
package rob_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned DEPTH  = 1 << TAG_W;
  localparam int unsigned BP_W   = 2;

  // One in-flight instruction awaiting in-order retirement.
  typedef struct packed {
    logic              valid;
    logic              done;
    logic [REG_W-1:0]  dest_reg;
    logic              we;
    logic [DATA_W-1:0] result;
    logic [BP_W-1:0]   bp;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ring pointer for the reorder buffer head/tail.
// Ports:
//   clk   - clock
//   i_rst - synchronous active-high reset to 0
//   i_clr - synchronous clear to 0 (flush)
//   i_inc - advance by one, wrapping at 2**W
//   o_ptr - current pointer value
module rob_ptr #(
  parameter int unsigned W = rob_pkg::TAG_W
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// 8-entry in-order reorder buffer behind the write-back stage.
// Entries are allocated in program order, completed out of order by
// write-back (indexed by ROB tag), and retired in order as register-file
// writes.
// Ports:
//   clk, reset, flush                      - clock, sync reset, discard all
//   alloc_valid/destReg/we, alloc_ready/tag - allocation handshake
//   wb_valid/tag/result/bp                 - write-back completion
//   commit_valid/we/destReg/result/bp/tag  - combinational retire port
//   count, empty, full                     - occupancy
module reorder_buffer #(
  parameter int unsigned DATA_W = rob_pkg::DATA_W,
  parameter int unsigned REG_W  = rob_pkg::REG_W,
  parameter int unsigned TAG_W  = rob_pkg::TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_destReg,
  input  logic              alloc_we,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [1:0]        wb_bp,
  output logic              commit_valid,
  output logic              commit_we,
  output logic [REG_W-1:0]  commit_destReg,
  output logic [DATA_W-1:0] commit_result,
  output logic [1:0]        commit_bp,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);

  import rob_pkg::*;

  localparam int unsigned CNT_W     = TAG_W + 1;
  localparam int unsigned N_ENTRIES = 1 << TAG_W;

  rob_entry_t       r_entries [N_ENTRIES];
  logic [CNT_W-1:0] r_count;

  logic [TAG_W-1:0] w_head;
  logic [TAG_W-1:0] w_tail;
  rob_entry_t       w_head_entry;
  logic             w_alloc;
  logic             w_wb;
  logic             w_commit;

  assign w_head_entry = r_entries[w_head];

  // Ready comes only from the registered count, so a same-cycle commit
  // never opens a slot for a same-cycle allocation.
  assign alloc_ready = (r_count != CNT_W'(N_ENTRIES));

  assign w_alloc  = alloc_valid & alloc_ready & ~flush & ~reset;
  assign w_wb     = wb_valid & r_entries[wb_tag].valid & ~flush & ~reset;
  assign w_commit = w_head_entry.valid & w_head_entry.done & ~flush & ~reset;

  rob_ptr #(.W(TAG_W)) u_head (
    .clk   (clk),
    .i_rst (reset),
    .i_clr (flush),
    .i_inc (w_commit),
    .o_ptr (w_head)
  );

  rob_ptr #(.W(TAG_W)) u_tail (
    .clk   (clk),
    .i_rst (reset),
    .i_clr (flush),
    .i_inc (w_alloc),
    .o_ptr (w_tail)
  );

  // Entry array. Write-back never hits the tail slot while an allocation
  // is possible (that slot is invalid unless full), and commit clears
  // valid last so a late write-back to the retiring head is harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_entries[TAG_W'(i)] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_entries[TAG_W'(i)].valid <= 1'b0;
        r_entries[TAG_W'(i)].done  <= 1'b0;
      end
    end else begin
      if (w_wb) begin
        r_entries[wb_tag].done   <= 1'b1;
        r_entries[wb_tag].result <= wb_result;
        r_entries[wb_tag].bp     <= wb_bp;
      end
      if (w_alloc) begin
        r_entries[w_tail].valid    <= 1'b1;
        r_entries[w_tail].done     <= 1'b0;
        r_entries[w_tail].dest_reg <= alloc_destReg;
        r_entries[w_tail].we       <= alloc_we;
      end
      if (w_commit) begin
        r_entries[w_head].valid <= 1'b0;
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count <= '0;
    end else if (w_alloc && !w_commit) begin
      r_count <= r_count + CNT_W'(1);
    end else if (!w_alloc && w_commit) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign alloc_tag      = w_tail;
  assign commit_valid   = w_commit;
  assign commit_we      = w_commit & w_head_entry.we;
  assign commit_destReg = w_head_entry.dest_reg;
  assign commit_result  = w_head_entry.result;
  assign commit_bp      = w_head_entry.bp;
  assign commit_tag     = w_head;
  assign count          = r_count;
  assign empty          = (r_count == '0);
  assign full           = ~alloc_ready;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed sequences plus a
// scoreboard queue of expected retirements in program order.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        alloc_valid;
  logic [2:0]  alloc_destReg;
  logic        alloc_we;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [15:0] wb_result;
  logic [1:0]  wb_bp;
  logic        commit_valid;
  logic        commit_we;
  logic [2:0]  commit_destReg;
  logic [15:0] commit_result;
  logic [1:0]  commit_bp;
  logic [2:0]  commit_tag;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .alloc_valid    (alloc_valid),
    .alloc_destReg  (alloc_destReg),
    .alloc_we       (alloc_we),
    .alloc_ready    (alloc_ready),
    .alloc_tag      (alloc_tag),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .wb_result      (wb_result),
    .wb_bp          (wb_bp),
    .commit_valid   (commit_valid),
    .commit_we      (commit_we),
    .commit_destReg (commit_destReg),
    .commit_result  (commit_result),
    .commit_bp      (commit_bp),
    .commit_tag     (commit_tag),
    .count          (count),
    .empty          (empty),
    .full           (full)
  );

  typedef struct {
    logic [2:0]  tag;
    logic [2:0]  dest;
    logic        we;
    logic        done;
    logic [15:0] res;
    logic [1:0]  bp;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] m_tail = 3'd0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard update at each active edge from the inputs presented.
  initial begin : model
    exp_t e;
    int   n;
    bit   cm;
    forever begin
      @(posedge clk);
      if (reset || flush) begin
        exp_q.delete();
        m_tail = 3'd0;
      end else begin
        n  = exp_q.size();
        cm = (n > 0) && exp_q[0].done;
        if (wb_valid) begin
          for (int i = 0; i < n; i++) begin
            if (exp_q[i].tag == wb_tag) begin
              exp_q[i].done = 1'b1;
              exp_q[i].res  = wb_result;
              exp_q[i].bp   = wb_bp;
            end
          end
        end
        if (cm) void'(exp_q.pop_front());
        if (alloc_valid && n < 8) begin
          e.tag  = m_tail;
          e.dest = alloc_destReg;
          e.we   = alloc_we;
          e.done = 1'b0;
          e.res  = 16'h0;
          e.bp   = 2'b0;
          exp_q.push_back(e);
          m_tail = m_tail + 3'd1;
        end
      end
    end
  end

  // Compare DUT outputs against the scoreboard mid-cycle.
  initial begin : monitor
    exp_t f;
    bit   exp_cv;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_cv = !reset && !flush && (exp_q.size() > 0) && exp_q[0].done;
        check_eq("commit_valid", 32'(commit_valid), 32'(exp_cv));
        if (exp_cv && commit_valid) begin
          f = exp_q[0];
          check_eq("commit_tag", 32'(commit_tag), 32'(f.tag));
          check_eq("commit_we", 32'(commit_we), 32'(f.we));
          check_eq("commit_destReg", 32'(commit_destReg), 32'(f.dest));
          check_eq("commit_result", 32'(commit_result), 32'(f.res));
          check_eq("commit_bp", 32'(commit_bp), 32'(f.bp));
        end
        check_eq("count", 32'(count), 32'(exp_q.size()));
        check_eq("full", 32'(full), 32'(exp_q.size() == 8));
        check_eq("empty", 32'(empty), 32'(exp_q.size() == 0));
        check_eq("alloc_ready", 32'(alloc_ready), 32'(exp_q.size() < 8));
        check_eq("alloc_tag", 32'(alloc_tag), 32'(m_tail));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [2:0] dest, input logic we);
    alloc_valid   = 1'b1;
    alloc_destReg = dest;
    alloc_we      = we;
    cyc();
    alloc_valid   = 1'b0;
  endtask

  task automatic do_wb(input logic [2:0] t, input logic [15:0] r, input logic [1:0] b);
    wb_valid  = 1'b1;
    wb_tag    = t;
    wb_result = r;
    wb_bp     = b;
    cyc();
    wb_valid  = 1'b0;
  endtask

  initial begin : stim
    logic [2:0] t0, t1, t2, tg, prev;
    logic [2:0] tags [5];
    bit         saw_wrap;

    reset = 1'b1; flush = 1'b0;
    alloc_valid = 1'b0; alloc_destReg = 3'd0; alloc_we = 1'b0;
    wb_valid = 1'b0; wb_tag = 3'd0; wb_result = 16'h0; wb_bp = 2'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check_eq("rst_commit_valid", 32'(commit_valid), 32'd0);
    check_eq("rst_commit_we", 32'(commit_we), 32'd0);
    check_eq("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check_eq("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_commit_tag", 32'(commit_tag), 32'd0);
    check_eq("rst_commit_dest", 32'(commit_destReg), 32'd0);
    check_eq("rst_commit_result", 32'(commit_result), 32'd0);
    check_eq("rst_commit_bp", 32'(commit_bp), 32'd0);
    mon_en = 1'b1;

    // Fill to full, then a rejected 9th allocation
    for (int i = 0; i < 8; i++) begin
      check_eq("fill_tag", 32'(alloc_tag), 32'(i));
      do_alloc(3'(i), 1'b1);
    end
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_ready", 32'(alloc_ready), 32'd0);
    check_eq("fill_count", 32'(count), 32'd8);
    do_alloc(3'd7, 1'b1);
    check_eq("ninth_count", 32'(count), 32'd8);
    check_eq("ninth_tag", 32'(alloc_tag), 32'd0);

    // Commit and alloc in the same cycle while full: alloc rejected
    do_wb(3'd0, 16'h1000, 2'b01);
    check_eq("full_commit_valid", 32'(commit_valid), 32'd1);
    do_alloc(3'd6, 1'b1);
    check_eq("full_commit_count", 32'(count), 32'd7);
    check_eq("full_commit_ready", 32'(alloc_ready), 32'd1);
    check_eq("full_commit_tag", 32'(alloc_tag), 32'd0);
    for (int i = 1; i < 8; i++) do_wb(3'(i), 16'h1000 + 16'(i), 2'(i));
    repeat (3) cyc();
    check_eq("drain_empty", 32'(empty), 32'd1);

    // Out-of-order completion, in-order retirement
    t0 = alloc_tag; do_alloc(3'd1, 1'b1);
    t1 = alloc_tag; do_alloc(3'd2, 1'b1);
    t2 = alloc_tag; do_alloc(3'd3, 1'b1);
    do_wb(t2, 16'h0CCC, 2'b11);
    check_eq("ooo_wait", 32'(commit_valid), 32'd0);
    do_wb(t0, 16'h0AAA, 2'b01);
    check_eq("ooo_c0_valid", 32'(commit_valid), 32'd1);
    check_eq("ooo_c0_result", 32'(commit_result), 32'h0AAA);
    do_wb(t1, 16'h0BBB, 2'b10);
    check_eq("ooo_c1_valid", 32'(commit_valid), 32'd1);
    check_eq("ooo_c1_result", 32'(commit_result), 32'h0BBB);
    cyc();
    check_eq("ooo_c2_valid", 32'(commit_valid), 32'd1);
    check_eq("ooo_c2_result", 32'(commit_result), 32'h0CCC);
    cyc();
    check_eq("ooo_done", 32'(commit_valid), 32'd0);
    check_eq("ooo_empty", 32'(empty), 32'd1);

    // Entry that does not write the register file
    t0 = alloc_tag;
    do_alloc(3'd5, 1'b0);
    do_wb(t0, 16'h1234, 2'b10);
    check_eq("nowe_valid", 32'(commit_valid), 32'd1);
    check_eq("nowe_we", 32'(commit_we), 32'd0);
    check_eq("nowe_dest", 32'(commit_destReg), 32'd5);
    cyc();

    // Steady streaming: alloc every cycle, wb one cycle later
    saw_wrap = 1'b0;
    prev = 3'd0;
    for (int i = 0; i < 20; i++) begin
      tg = alloc_tag;
      if (i > 0 && tg == 3'd0) saw_wrap = 1'b1;
      alloc_valid   = 1'b1;
      alloc_destReg = 3'(i);
      alloc_we      = 1'b1;
      if (i > 0) begin
        wb_valid  = 1'b1;
        wb_tag    = prev;
        wb_result = 16'h2000 + 16'(i);
        wb_bp     = 2'(i);
      end
      cyc();
      alloc_valid = 1'b0;
      wb_valid    = 1'b0;
      check_eq("ss_count_range", 32'(count >= 4'd1 && count <= 4'd2), 32'd1);
      check_eq("ss_commit", 32'(commit_valid), 32'(i > 0));
      prev = tg;
    end
    do_wb(prev, 16'h2FFF, 2'b11);
    check_eq("ss_last_commit", 32'(commit_valid), 32'd1);
    cyc();
    check_eq("ss_wrap", 32'(saw_wrap), 32'd1);
    check_eq("ss_empty", 32'(empty), 32'd1);

    // Flush with pending entries and a concurrent wb/alloc
    for (int i = 0; i < 5; i++) begin
      tags[i] = alloc_tag;
      do_alloc(3'(i + 1), 1'b1);
    end
    do_wb(tags[0], 16'h3000, 2'b01);
    flush       = 1'b1;
    wb_valid    = 1'b1;
    wb_tag      = tags[2];
    wb_result   = 16'h3333;
    alloc_valid = 1'b1;
    #1;
    check_eq("flush_no_commit", 32'(commit_valid), 32'd0);
    cyc();
    flush = 1'b0; wb_valid = 1'b0; alloc_valid = 1'b0;
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_empty", 32'(empty), 32'd1);
    check_eq("flush_commit", 32'(commit_valid), 32'd0);
    check_eq("flush_tag", 32'(alloc_tag), 32'd0);
    do_wb(tags[2], 16'h4444, 2'b10);
    check_eq("stale_wb_commit", 32'(commit_valid), 32'd0);
    check_eq("stale_wb_count", 32'(count), 32'd0);
    do_alloc(3'd4, 1'b1);
    do_wb(3'd0, 16'h5555, 2'b11);
    check_eq("post_flush_valid", 32'(commit_valid), 32'd1);
    check_eq("post_flush_result", 32'(commit_result), 32'h5555);
    cyc();

    // Reset mid-stream
    do_alloc(3'd1, 1'b1);
    do_alloc(3'd2, 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_eq("midrst_count", 32'(count), 32'd0);
    check_eq("midrst_tag", 32'(alloc_tag), 32'd0);
    check_eq("midrst_commit", 32'(commit_valid), 32'd0);

    repeat (2) cyc();
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
